// File: rtl/module_antirrebote_pkg.sv
// Shared types and helpers for the push-button conditioning chain.
package pkg_antirrebote;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        HOLD,
        RELEASE_WAIT
    } state_t;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/module_antirrebote_sync_2ff.sv
// Two-flop synchronizer for asynchronous pins and switches.
module module_sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= RST_VAL;
            q_o  <= RST_VAL;
        end else begin
            s1_q <= d_i;
            q_o  <= s1_q;
        end
    end

endmodule

// File: rtl/module_antirrebote.sv
// Push-button debouncer with press, release and auto-repeat pulses.
module module_antirrebote
    import pkg_antirrebote::*;
#(
    parameter int DEBOUNCE   = 270000,
    parameter int HOLD       = 13500000,
    parameter int REPEAT     = 2700000,
    parameter int ACTIVE_LOW = 1,
    parameter int EN_REPEAT  = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic repeat_o
);

    localparam int CW = cnt_width(DEBOUNCE, HOLD, REPEAT);
    localparam logic [CW-1:0] DEB_T  = CW'(DEBOUNCE - 1);
    localparam logic [CW-1:0] HOLD_T = CW'(HOLD - 1);
    localparam logic [CW-1:0] REP_T  = CW'(REPEAT - 1);
    localparam logic IDLE_PIN = (ACTIVE_LOW != 0);

    logic          sync_s2;
    logic          pressed_raw;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_d, press_d, release_d, repeat_d;

    module_sync_2ff #(
        .RST_VAL (IDLE_PIN)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (btn_i),
        .q_o (sync_s2)
    );

    assign pressed_raw = IDLE_PIN ? ~sync_s2 : sync_s2;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CW'(1);
        press_d   = 1'b0;
        release_d = 1'b0;
        repeat_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (pressed_raw) state_d = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (!pressed_raw) begin
                    state_d = IDLE;
                end else if (cnt_q == DEB_T) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                end
            end
            PRESSED: begin
                if (!pressed_raw) begin
                    state_d = RELEASE_WAIT;
                end else if (EN_REPEAT != 0 && cnt_q == HOLD_T) begin
                    state_d  = pkg_antirrebote::HOLD;
                    repeat_d = 1'b1;
                end else if (cnt_q == '1) begin
                    cnt_d = cnt_q;
                end
            end
            pkg_antirrebote::HOLD: begin
                if (!pressed_raw) begin
                    state_d = RELEASE_WAIT;
                end else if (cnt_q == REP_T) begin
                    repeat_d = 1'b1;
                    cnt_d    = '0;
                end
            end
            RELEASE_WAIT: begin
                if (pressed_raw) begin
                    state_d = PRESSED;
                end else if (cnt_q == DEB_T) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Any state change restarts timing, so the counter never wraps
        if (state_d != state_q) cnt_d = '0;
        level_d = (state_d == PRESSED) ||
                  (state_d == pkg_antirrebote::HOLD) ||
                  (state_d == RELEASE_WAIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_o   <= 1'b0;
            press_o   <= 1'b0;
            release_o <= 1'b0;
            repeat_o  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_o   <= level_d;
            press_o   <= press_d;
            release_o <= release_d;
            repeat_o  <= repeat_d;
        end
    end

endmodule

// File: tb/tb_module_antirrebote.sv
// Bench for module_antirrebote: directed scenarios plus random pin noise.
module tb_module_antirrebote;

    localparam int D = 4;
    localparam int H = 10;
    localparam int R = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn = 1'b1;
    logic lvl_a, prs_a, rel_a, rep_a;
    logic lvl_b, prs_b, rel_b, rep_b;

    int tests = 0;
    int fails = 0;

    // Reference model: raw pin pipeline plus run-length bookkeeping
    logic m_s1, m_s2;
    logic m_lvl, m_prs, m_rel, m_rep;
    int   m_run, m_since;
    bit   m_rep_on;

    always #5 clk = ~clk;

    module_antirrebote #(
        .DEBOUNCE (D), .HOLD (H), .REPEAT (R),
        .ACTIVE_LOW (1), .EN_REPEAT (1)
    ) u_dut (
        .clk (clk), .rst (rst), .btn_i (btn),
        .level_o (lvl_a), .press_o (prs_a),
        .release_o (rel_a), .repeat_o (rep_a)
    );

    module_antirrebote #(
        .DEBOUNCE (D), .HOLD (H), .REPEAT (R),
        .ACTIVE_LOW (1), .EN_REPEAT (0)
    ) u_norep (
        .clk (clk), .rst (rst), .btn_i (btn),
        .level_o (lvl_b), .press_o (prs_b),
        .release_o (rel_b), .repeat_o (rep_b)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic b, input logic r);
        logic pr;
        m_prs = 1'b0;
        m_rel = 1'b0;
        m_rep = 1'b0;
        if (r) begin
            m_s1 = 1'b1; m_s2 = 1'b1;
            m_lvl = 1'b0; m_run = 0; m_since = 0; m_rep_on = 0;
            return;
        end
        pr   = ~m_s2;
        m_s2 = m_s1;
        m_s1 = b;
        if (!m_lvl) begin
            m_run = pr ? m_run + 1 : 0;
            if (m_run == D + 1) begin
                m_lvl = 1'b1; m_prs = 1'b1;
                m_run = 0; m_since = 0; m_rep_on = 0;
            end
        end else if (!pr) begin
            m_run++;
            m_rep_on = 0;
            if (m_run == D + 1) begin
                m_lvl = 1'b0; m_rel = 1'b1; m_run = 0;
            end
        end else begin
            if (m_run > 0) begin
                m_since = 0;
            end else begin
                m_since++;
                if (!m_rep_on && m_since == H) begin
                    m_rep = 1'b1; m_rep_on = 1; m_since = 0;
                end else if (m_rep_on && m_since == R) begin
                    m_rep = 1'b1; m_since = 0;
                end
            end
            m_run = 0;
        end
    endtask

    task automatic tick(input logic b, input logic r);
        btn = b;
        rst = r;
        @(posedge clk);
        model_step(b, r);
        #1;
        chk("level",   lvl_a, m_lvl);
        chk("press",   prs_a, m_prs);
        chk("release", rel_a, m_rel);
        chk("repeat",  rep_a, m_rep);
        chk("norep_level",  lvl_b, m_lvl);
        chk("norep_press",  prs_b, m_prs);
        chk("norep_repeat", rep_b, 1'b0);
    endtask

    initial begin
        m_s1 = 1'b1; m_s2 = 1'b1; m_lvl = 1'b0;
        m_prs = 0; m_rel = 0; m_rep = 0;
        m_run = 0; m_since = 0; m_rep_on = 0;

        // Reset
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        chk("rst_level", lvl_a, 1'b0);
        chk("rst_state", u_dut.state_q == pkg_antirrebote::IDLE, 1'b1);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);

        // Glitch rejection
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1'b0);
            chk("glitch_level", lvl_a, 1'b0);
            chk("glitch_press", prs_a, 1'b0);
        end
        chk("glitch_idle", u_dut.state_q == pkg_antirrebote::IDLE, 1'b1);

        // Clean press and auto-repeat, edges numbered from 1
        for (int e = 1; e <= 26; e++) begin
            tick(1'b0, 1'b0);
            chk("press_edge", prs_a, e == 7);
            chk("level_edge", lvl_a, e >= 7);
            chk("repeat_edge", rep_a, e == 17 || e == 20 || e == 23 || e == 26);
        end

        // Release bounce while held
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        for (int i = 0; i < 14; i++) begin
            tick(1'b0, 1'b0);
            chk("bounce_level", lvl_a, 1'b1);
            chk("bounce_release", rel_a, 1'b0);
        end

        // Final release
        for (int e = 1; e <= 9; e++) begin
            tick(1'b1, 1'b0);
            chk("release_edge", rel_a, e == 7);
            chk("release_level", lvl_a, e < 7);
        end

        // Reset in the middle of HOLD
        for (int i = 0; i < 25; i++) tick(1'b0, 1'b0);
        chk("hold_reached", u_dut.state_q == pkg_antirrebote::HOLD, 1'b1);
        tick(1'b1, 1'b1);
        chk("midrst_level", lvl_a, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b0);
            chk("midrst_release", rel_a, 1'b0);
        end

        // Random pin activity: steady stretches mixed with bouncy ones
        for (int s = 0; s < 120; s++) begin
            int len;
            logic lv;
            len = $urandom_range(1, 30);
            lv  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) begin
                tick(lv, 1'b1);
            end else if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < len; i++) tick(1'($urandom_range(0, 1)), 1'b0);
            end else begin
                for (int i = 0; i < len; i++) tick(lv, 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
